// File: rtl/rx_link_pkg.sv
// Shared types for the receive-link controller: state encoding, config record, defaults.
package rx_link_pkg;

   typedef enum logic [1:0] {
      ST_RESET  = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HUNT   = 2'd2,
      ST_LOCKED = 2'd3
   } rx_state_e;

   typedef struct packed {
      logic [3:0]  ss;
      logic [2:0]  m;
      logic [2:0]  bw;
      logic [23:0] thr;
      logic        auto_thr;
   } rx_cfg_t;

   localparam logic [23:0] THR_DEFAULT = 24'hFFFFFF;
   localparam rx_cfg_t CFG_DEFAULT = '{ss: 4'd0, m: 3'd0, bw: 3'd0, thr: THR_DEFAULT, auto_thr: 1'b0};

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (clr_i)
         cnt_q <= '0;
      else if (inc_i && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/rx_link_ctrl.sv
// Receive-chain sequencer: datapath reset/settle, preamble hunt, lock supervision, config apply.
// Define RX_LINK_STATS_EN to build the pkt/crc_err/relock statistics counters (else they read 0).
//   state  | meaning
//   RESET  | dp_rst_n low, shadow config applied on entry
//   SETTLE | datapath released, waiting for it to settle
//   HUNT   | searching for preamble, bounded by HUNT_TMO
//   LOCKED | link up, CRC verdicts supervised
module rx_link_ctrl
   import rx_link_pkg::*;
#(
   parameter int RST_CYC     = 16,
   parameter int SETTLE_CYC  = 256,
   parameter int HUNT_TMO    = 1000000,
   parameter int MAX_CRC_ERR = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       cfg_ss,
   input  logic [2:0]       cfg_m,
   input  logic [2:0]       cfg_bw,
   input  logic [23:0]      cfg_thr,
   input  logic             cfg_auto_thr,
   input  logic             cfg_wr,
   input  logic [23:0]      thr_lvl_auto,
   input  logic             corr_pr_detect,
   input  logic             decrc_verr,
   input  logic             decrc_oerr,
   output logic [3:0]       ss_out,
   output logic [2:0]       m_out,
   output logic [2:0]       bw_out,
   output logic [23:0]      thr_lvl_out,
   output logic             dp_rst_n,
   output logic [1:0]       state_o,
   output logic             link_up,
   output logic             cfg_pending,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] crc_err_cnt,
   output logic [CNT_W-1:0] relock_cnt
);

   localparam int TMR_W = $clog2(max3(RST_CYC, SETTLE_CYC, HUNT_TMO) + 1);
   localparam int ERR_W = $clog2(MAX_CRC_ERR + 1);
   localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYC - 1);
   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
   localparam logic [TMR_W-1:0] HUNT_LAST   = TMR_W'(HUNT_TMO - 1);
   localparam logic [ERR_W-1:0] ERR_LAST    = ERR_W'(MAX_CRC_ERR - 1);

   rx_state_e        state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [ERR_W-1:0] consec_q, consec_d;
   logic             inflight_q, inflight_d;
   logic             enter_rst;
   logic             crc_relock;
   rx_cfg_t          shadow_q;
   logic             pend_q;
   logic [3:0]       ss_q;
   logic [2:0]       m_q, bw_q;
   logic [23:0]      thr_q;
   logic             auto_q;
   logic             dp_rst_n_q, link_up_q;

   assign crc_relock = (state_q == ST_LOCKED) && decrc_verr && decrc_oerr && (consec_q == ERR_LAST);

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q + TMR_W'(1);
      consec_d   = consec_q;
      inflight_d = inflight_q;
      enter_rst  = 1'b0;
      case (state_q)
         ST_RESET: begin
            if (tmr_q == RST_LAST) begin
               state_d = ST_SETTLE;
               tmr_d   = '0;
            end
         end
         ST_SETTLE: begin
            if (tmr_q == SETTLE_LAST) begin
               state_d = ST_HUNT;
               tmr_d   = '0;
            end
         end
         ST_HUNT: begin
            if (pend_q)
               enter_rst = 1'b1;
            else if (corr_pr_detect) begin
               state_d    = ST_LOCKED;
               consec_d   = '0;
               inflight_d = 1'b1;
            end else if (tmr_q == HUNT_LAST)
               enter_rst = 1'b1;
         end
         ST_LOCKED: begin
            tmr_d = tmr_q;
            // a new preamble in the verdict cycle belongs to the next packet
            if (corr_pr_detect)
               inflight_d = 1'b1;
            else if (decrc_verr)
               inflight_d = 1'b0;
            if (decrc_verr)
               consec_d = decrc_oerr ? consec_q + ERR_W'(1) : '0;
            if (crc_relock || (pend_q && (!inflight_q || decrc_verr)))
               enter_rst = 1'b1;
         end
         default: state_d = ST_RESET;
      endcase
      if (enter_rst) begin
         state_d = ST_RESET;
         tmr_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RESET;
         tmr_q      <= '0;
         consec_q   <= '0;
         inflight_q <= 1'b0;
         shadow_q   <= CFG_DEFAULT;
         pend_q     <= 1'b0;
         ss_q       <= '0;
         m_q        <= '0;
         bw_q       <= '0;
         thr_q      <= THR_DEFAULT;
         auto_q     <= 1'b0;
         dp_rst_n_q <= 1'b0;
         link_up_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         consec_q   <= consec_d;
         inflight_q <= inflight_d;
         dp_rst_n_q <= (state_d != ST_RESET);
         link_up_q  <= (state_d == ST_LOCKED);
         if (enter_rst) begin
            ss_q   <= shadow_q.ss;
            m_q    <= shadow_q.m;
            bw_q   <= shadow_q.bw;
            auto_q <= shadow_q.auto_thr;
            thr_q  <= shadow_q.auto_thr ? thr_lvl_auto : shadow_q.thr;
         end else if (auto_q && (state_q != ST_LOCKED))
            thr_q <= thr_lvl_auto;
         // a write landing on the apply cycle stays pending for the next RESET entry
         if (cfg_wr) begin
            shadow_q <= '{ss: cfg_ss, m: cfg_m, bw: cfg_bw, thr: cfg_thr, auto_thr: cfg_auto_thr};
            pend_q   <= 1'b1;
         end else if (enter_rst)
            pend_q <= 1'b0;
      end
   end

   assign ss_out      = ss_q;
   assign m_out       = m_q;
   assign bw_out      = bw_q;
   assign thr_lvl_out = thr_q;
   assign dp_rst_n    = dp_rst_n_q;
   assign state_o     = state_q;
   assign link_up     = link_up_q;
   assign cfg_pending = pend_q;

`ifdef RX_LINK_STATS_EN
   logic pkt_inc, err_inc;
   assign pkt_inc = (state_q == ST_LOCKED) && decrc_verr;
   assign err_inc = pkt_inc && decrc_oerr;

   sat_cnt #(.CNT_W(CNT_W)) u_pkt_cnt (.clk(clk), .clr_i(rst), .inc_i(pkt_inc),    .cnt_o(pkt_cnt));
   sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (.clk(clk), .clr_i(rst), .inc_i(err_inc),    .cnt_o(crc_err_cnt));
   sat_cnt #(.CNT_W(CNT_W)) u_rel_cnt (.clk(clk), .clr_i(rst), .inc_i(crc_relock), .cnt_o(relock_cnt));
`else
   assign pkt_cnt     = '0;
   assign crc_err_cnt = '0;
   assign relock_cnt  = '0;
`endif

endmodule
